alu_cmd_sequencer: RTL

Upstream issue stage for the 8-bit combinational ALU. It accepts operation commands (a, b, sel) over a valid/ready interface and buffers them in a small FIFO. It issues one command at a time to the ALU on registered operand lines, captures the ALU result and presents it downstream with valid/ready, a zero flag and a divide-by-zero flag.

---
 rtl/alu_cmd_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: buffers commands in a FIFO, drives registered
// operands one at a time, and presents each captured result with valid/ready and flags.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [2:0]               cmd_sel,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_sel,
    input  logic [WIDTH-1:0]         alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [2:0]               res_sel,
    output logic                     res_zero,
    output logic                     res_dz,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem_a_q   [DEPTH];
    logic [WIDTH-1:0] mem_b_q   [DEPTH];
    logic [2:0]       mem_sel_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full       = (count_q == CntFull);
    assign empty      = (count_q == '0);
    assign cmd_ready  = !full;
    assign fifo_count = count_q;
    assign push       = cmd_valid && !full;
    // A pop only ever happens as part of an issue transition.
    assign pop        = !empty && ((state_q == StIdle) || ((state_q == StHold) && res_ready));

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]   <= cmd_a;
            mem_b_q[wr_ptr_q]   <= cmd_b;
            mem_sel_q[wr_ptr_q] <= cmd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
            res_zero  <= 1'b0;
            res_dz    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                alu_a    <= mem_a_q[rd_ptr_q];
                alu_b    <= mem_b_q[rd_ptr_q];
                alu_sel  <= mem_sel_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    res_data  <= alu_out;
                    res_sel   <= alu_sel;
                    res_zero  <= (alu_out == '0);
                    res_dz    <= (alu_sel == 3'b011) && (alu_b == '0);
                    res_valid <= 1'b1;
                    state_q   <= StHold;
                end
                StHold: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= empty ? StIdle : StExec;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
